pwm_demod: RTL and testbench

Receive-side decoder for the ICE PWM serial line. Samples a PWM-encoded input in which every bit period starts with a rising edge and carries a long high pulse (~80 % of the period) for a 1 and a short high pulse (~20 %) for a 0, LSB first, 10·base_counter cycles per bit. Recovers bytes and pushes them into the downstream receive FIFO. Sits between the board-level PWM input pin and the RX byte FIFO, sharing the same base_counter timing register as the PWM transmitter.

---
 rtl/pwm_demod.sv | 222 ++++++++++++++++++++++
 tb/tb_pwm_demod.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pwm_demod: ICE PWM line receiver, pulse-width bit decode into RX FIFO. |
// | Optional glitch filter: define PWM_DEMOD_GLITCH_FILTER_EN.            |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pwm_demod #(
  parameter int BITS_PER_DC = 22
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   PWM_IN,
  input  logic [BITS_PER_DC-1:0] base_counter,
  input  logic                   rx_en,
  output logic [7:0]             fifo_dout,
  output logic                   fifo_WE,
  input  logic                   fifo_full,
  output logic                   frame_err,
  output logic                   ovf_err
);

  localparam int CNT_W = BITS_PER_DC + 5;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HIGH  = 2'd1;
  localparam logic [1:0] ST_LOW   = 2'd2;
  localparam logic [1:0] ST_STUCK = 2'd3;

  logic             sync1_q, sync2_q;
  logic             s, s_d_q;
  logic             rise, fall;
  logic             active;
  logic [CNT_W-1:0] bc_ext, thr, per, gap;
  logic             hi_timeout, lo_timeout;
  logic             new_bit;
  logic [7:0]       new_byte;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       fifo_dout_q, fifo_dout_d;
  logic             fifo_we_q, fifo_we_d;
  logic             frame_err_q, frame_err_d;
  logic             ovf_err_q, ovf_err_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= PWM_IN;
      sync2_q <= sync1_q;
    end
  end

`ifdef PWM_DEMOD_GLITCH_FILTER_EN
  // The line only moves once three consecutive synchronized samples agree.
  logic flt1_q, flt2_q, filt_q, filt_d;

  always_comb begin
    filt_d = filt_q;
    if ((sync2_q == flt1_q) && (sync2_q == flt2_q)) filt_d = sync2_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flt1_q <= 1'b0;
      flt2_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      flt1_q <= sync2_q;
      flt2_q <= flt1_q;
      filt_q <= filt_d;
    end
  end

  assign s = filt_d;
`else
  assign s = sync2_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) s_d_q <= 1'b0;
    else         s_d_q <= s;
  end

  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  assign active = rx_en && (base_counter != '0);
  assign bc_ext = {5'b0, base_counter};
  assign thr    = (bc_ext << 2) + bc_ext;
  assign per    = (bc_ext << 3) + (bc_ext << 1);
  assign gap    = per << 1;

  assign hi_timeout = (hcnt_q >= per);
  assign lo_timeout = (lcnt_q >= gap);
  assign new_bit    = (hcnt_q >= thr);
  assign new_byte   = {new_bit, shift_q[7:1]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!active) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (rise) state_d = ST_HIGH;
        ST_HIGH: begin
          if (fall)            state_d = ST_LOW;
          else if (hi_timeout) state_d = ST_STUCK;
        end
        ST_LOW: begin
          if (rise)            state_d = ST_HIGH;
          else if (lo_timeout) state_d = ST_IDLE;
        end
        ST_STUCK: if (fall) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    fifo_dout_d = fifo_dout_q;
    fifo_we_d   = 1'b0;
    frame_err_d = 1'b0;
    ovf_err_d   = 1'b0;
    if (!active) begin
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
          if (rise) hcnt_d = CNT_ONE;
        end
        ST_HIGH: begin
          if (fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            lcnt_d    = CNT_ONE;
            // Eighth bit: bit_cnt wraps and the byte leaves either way.
            if (bit_cnt_q == 3'd7) begin
              shift_d = 8'h00;
              if (!fifo_full) begin
                fifo_we_d   = 1'b1;
                fifo_dout_d = new_byte;
              end else begin
                ovf_err_d = 1'b1;
              end
            end else begin
              shift_d = new_byte;
            end
          end else if (hi_timeout) begin
            frame_err_d = 1'b1;
            bit_cnt_d   = 3'd0;
            shift_d     = 8'h00;
          end else begin
            hcnt_d = sat_inc(hcnt_q);
          end
        end
        ST_LOW: begin
          if (rise) begin
            hcnt_d = CNT_ONE;
          end else if (lo_timeout) begin
            frame_err_d = (bit_cnt_q != 3'd0);
            bit_cnt_d   = 3'd0;
            shift_d     = 8'h00;
          end else begin
            lcnt_d = sat_inc(lcnt_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      fifo_dout_q <= 8'h00;
      fifo_we_q   <= 1'b0;
      frame_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      lcnt_q      <= lcnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      fifo_dout_q <= fifo_dout_d;
      fifo_we_q   <= fifo_we_d;
      frame_err_q <= frame_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign fifo_dout = fifo_dout_q;
  assign fifo_WE   = fifo_we_q;
  assign frame_err = frame_err_q;
  assign ovf_err   = ovf_err_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_demod.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pwm_demod: scoreboard bench for pwm_demod with a byte vector table. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pwm_demod;

  localparam int K_WE    = 0;
  localparam int K_FRAME = 1;
  localparam int K_OVF   = 2;
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
  localparam int BC_MIN = 2;
`else
  localparam int BC_MIN = 1;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        PWM_IN = 1'b0;
  logic [21:0] base_counter = 22'd4;
  logic        rx_en = 1'b0;
  logic        fifo_full = 1'b0;
  logic [7:0]  fifo_dout;
  logic        fifo_WE;
  logic        frame_err;
  logic        ovf_err;

  pwm_demod #(.BITS_PER_DC(22)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .PWM_IN       (PWM_IN),
    .base_counter (base_counter),
    .rx_en        (rx_en),
    .fifo_dout    (fifo_dout),
    .fifo_WE      (fifo_WE),
    .fifo_full    (fifo_full),
    .frame_err    (frame_err),
    .ovf_err      (ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       full_last;
    int         bc;
    int         idle_after;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic got_ev(input int kind, input logic [7:0] data);
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d data %0h, expected none", kind, data);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || (kind == K_WE && e.data != data)) begin
        n_fail++;
        $display("FAIL event_order: got kind %0d data %0h, expected kind %0d data %0h",
                 kind, data, e.kind, e.data);
      end
    end
  endtask

  task automatic level(input logic v, input int n);
    PWM_IN = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int bc);
    int hi;
    hi = b ? 8 * bc - 1 : 2 * bc - 1;
    level(1'b1, hi);
    level(1'b0, 10 * bc - hi);
  endtask

  task automatic send_bits(input logic [7:0] d, input int n, input int bc);
    for (int i = 0; i < n; i++) send_bit(d[i], bc);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic full_last, input int bc);
    expect_ev(full_last ? K_OVF : K_WE, d);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) fifo_full = full_last;
      send_bit(d[i], bc);
    end
    fifo_full = 1'b0;
  endtask

  task automatic drained(input string name);
    chk(name, sb.size(), 0);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (resetn) begin
          if (fifo_WE)   got_ev(K_WE, fifo_dout);
          if (ovf_err)   got_ev(K_OVF, 8'h00);
          if (frame_err) got_ev(K_FRAME, 8'h00);
        end
      end
      begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
      end
    join_none

    vecs[0] = '{8'hA5, 1'b0, 4, 30};
    vecs[1] = '{8'h00, 1'b0, 4, 0};
    vecs[2] = '{8'hFF, 1'b0, 4, 0};
    vecs[3] = '{8'h3C, 1'b0, 4, 100};
    vecs[4] = '{8'h77, 1'b1, 4, 30};
    vecs[5] = '{8'h12, 1'b0, 4, 30};
    vecs[6] = '{8'hE7, 1'b0, BC_MIN, 40};

    rx_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dout", fifo_dout, 0);
    chk("reset_we", fifo_WE, 0);
    chk("reset_frame", frame_err, 0);
    chk("reset_ovf", ovf_err, 0);
    resetn = 1'b1;
    level(1'b0, 5);

    for (int i = 0; i < 7; i++) begin
      base_counter = 22'(vecs[i].bc);
      send_byte(vecs[i].data, vecs[i].full_last, vecs[i].bc);
      level(1'b0, vecs[i].idle_after);
      if (vecs[i].idle_after > 0) drained($sformatf("vec%0d_drain", i));
    end
    base_counter = 22'd4;
    level(1'b0, 10);

    // Partial byte followed by a long low line.
    send_bits(8'h05, 3, 4);
    expect_ev(K_FRAME, 8'h00);
    level(1'b0, 100);
    drained("timeout_frame");
    send_byte(8'h81, 1'b0, 4);
    level(1'b0, 30);
    drained("after_timeout_81");

    // Line stuck high mid-byte.
    send_bits(8'h01, 2, 4);
    expect_ev(K_FRAME, 8'h00);
    level(1'b1, 60);
    level(1'b0, 10);
    drained("stuck_frame");
    send_byte(8'h5A, 1'b0, 4);
    level(1'b0, 30);
    drained("after_stuck_5A");

    // 0xC3 with a 2-cycle glitch inside the low part of bit 0.
`ifdef PWM_DEMOD_GLITCH_FILTER_EN
    expect_ev(K_WE, 8'hC3);
`else
    expect_ev(K_WE, 8'h85);
    expect_ev(K_FRAME, 8'h00);
`endif
    level(1'b1, 31);
    level(1'b0, 3);
    level(1'b1, 2);
    level(1'b0, 4);
    for (int i = 1; i < 8; i++) send_bit(8'hC3 >> i, 4);
    level(1'b0, 100);
    drained("glitch_C3");

    // Receive disabled mid-byte; nothing may come out of the abandoned bits.
    send_bits(8'h0F, 4, 4);
    rx_en = 1'b0;
    send_bits(8'h03, 2, 4);
    level(1'b0, 5);
    rx_en = 1'b1;
    level(1'b0, 5);
    drained("rx_en_drop");
    send_byte(8'h96, 1'b0, 4);
    level(1'b0, 30);
    drained("after_rx_en_96");

    // Asynchronous reset in the middle of a high pulse.
    send_bits(8'h55, 5, 4);
    PWM_IN = 1'b1;
    repeat (5) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_dout", fifo_dout, 0);
    chk("async_rst_we", fifo_WE, 0);
    @(negedge clk);
    PWM_IN = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    level(1'b0, 10);
    send_byte(8'h42, 1'b0, 4);
    level(1'b0, 30);
    drained("after_reset_42");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
